// File: rtl/seg7_pkg.sv
// seg7_pkg
//   Shared definitions for the multiplexed 7-segment display driver:
//   blanking value, segment bit positions on the seg bus, the slot phase
//   type, and the hex font lookup (active-low, {g,f,e,d,c,b,a}).
package seg7_pkg;

    // All segments dark (active-low bus).
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Bit position of each segment on the seg output bus.
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Phase inside a digit slot: dead-time blanking, then lit window.
    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_ON    = 1'b1
    } phase_t;

    // Hex nibble to active-low segment pattern. The table is written in
    // {g,f,e,d,c,b,a} order; the SEG_x positions then place each segment
    // on its bus bit, so a board with a different pin order only touches
    // the constants above.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] code;
        logic [6:0] bus;
        case (nibble)
            4'h0:    code = 7'h40;
            4'h1:    code = 7'h79;
            4'h2:    code = 7'h24;
            4'h3:    code = 7'h30;
            4'h4:    code = 7'h19;
            4'h5:    code = 7'h12;
            4'h6:    code = 7'h02;
            4'h7:    code = 7'h78;
            4'h8:    code = 7'h00;
            4'h9:    code = 7'h10;
            4'hA:    code = 7'h08;
            4'hB:    code = 7'h03;
            4'hC:    code = 7'h46;
            4'hD:    code = 7'h21;
            4'hE:    code = 7'h06;
            default: code = 7'h0E;
        endcase
        bus        = SEG_OFF;
        bus[SEG_A] = code[0];
        bus[SEG_B] = code[1];
        bus[SEG_C] = code[2];
        bus[SEG_D] = code[3];
        bus[SEG_E] = code[4];
        bus[SEG_F] = code[5];
        bus[SEG_G] = code[6];
        return bus;
    endfunction

endpackage

// File: rtl/seg7_pwm.sv
// seg7_pwm
//   Brightness modulator for one lit window. A free-running counter is
//   restarted so it reads 0 on the first lit cycle of each slot; the
//   digit may be lit while the counter is <= the brightness code.
// Ports
//   clk         in  system clock, rising edge
//   reset       in  asynchronous, active-low reset
//   restart     in  1 = counter reads 0 on the next cycle
//   brightness  in  duty code, all-ones = always lit
//   lit         out 1 = current cycle is inside the duty window
module seg7_pwm #(
    parameter int BRIGHT_W = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                restart,
    input  logic [BRIGHT_W-1:0] brightness,
    output logic                lit
);

    logic [BRIGHT_W-1:0] pwm_cnt_p1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pwm_cnt_p1 <= '0;
        end else if (restart) begin
            pwm_cnt_p1 <= '0;
        end else begin
            pwm_cnt_p1 <= pwm_cnt_p1 + 1'b1;
        end
    end

    assign lit = (pwm_cnt_p1 <= brightness);

endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux
//   Time-multiplexed driver for an N-digit common-anode 7-segment display.
//   Each digit owns a fixed-length slot: a dead-time blanking phase with
//   all anodes off (segments switch here), then a PWM-modulated lit phase.
//   New content is staged in a shadow buffer and committed only at the
//   frame boundary so a frame never mixes old and new digits.
// Ports
//   clk          in  system clock, rising edge
//   reset        in  asynchronous, active-low reset
//   digits_in    in  nibble k = value of digit k
//   dp_in        in  1 = decimal point k lit
//   digit_en     in  1 = digit k displayed
//   brightness   in  duty code, all-ones = full on
//   load         in  strobe: capture digits_in/dp_in/digit_en
//   load_ack     out 1-cycle pulse when staged content goes live
//   frame_start  out 1-cycle pulse at start of the digit-0 slot
//   an           out anodes, active-low
//   seg          out segments {g..a}, active-low
//   dp           out decimal point, active-low
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SLOT_CYCLES  = 100000,
    parameter int BLANK_CYCLES = 16,
    parameter int BRIGHT_W     = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [BRIGHT_W-1:0]     brightness,
    input  logic                    load,
    output logic                    load_ack,
    output logic                    frame_start,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp
);

    localparam int SLOT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYCLES - 1);
    localparam logic [SLOT_W-1:0] BLANK_END = SLOT_W'(BLANK_CYCLES);
    // Restart the PWM counter on the last blank cycle so it reads 0 on
    // the first lit cycle.
    localparam logic [SLOT_W-1:0] PWM_START = SLOT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [SLOT_W-1:0]       slot_cnt;
    logic [IDX_W-1:0]        idx;

    logic [4*NUM_DIGITS-1:0] shadow_digits;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [NUM_DIGITS-1:0]   shadow_en;
    logic                    pending;

    logic [4*NUM_DIGITS-1:0] active_digits;
    logic [NUM_DIGITS-1:0]   active_dp;
    logic [NUM_DIGITS-1:0]   active_en;

    logic                    slot_last;
    logic                    frame_wrap;
    logic                    pwm_lit;
    logic [3:0]              nibble;
    phase_t                  phase;
    logic [NUM_DIGITS-1:0]   an_nxt;

    logic [NUM_DIGITS-1:0]   an_p1;
    logic [6:0]              seg_p1;
    logic                    dp_p1;
    logic                    load_ack_p1;
    logic                    frame_start_p1;

    seg7_pwm #(
        .BRIGHT_W (BRIGHT_W)
    ) u_pwm (
        .clk        (clk),
        .reset      (reset),
        .restart    (slot_cnt == PWM_START),
        .brightness (brightness),
        .lit        (pwm_lit)
    );

    // Stage 0: decode of the current slot position
    always_comb begin
        slot_last  = (slot_cnt == SLOT_LAST);
        frame_wrap = slot_last && (idx == IDX_LAST);
        nibble     = active_digits[{idx, 2'b00} +: 4];
        phase      = (slot_cnt < BLANK_END) ? PH_BLANK : PH_ON;
        an_nxt     = '1;
        if (phase == PH_ON && active_en[idx] && pwm_lit) begin
            an_nxt[idx] = 1'b0;
        end
    end

    // Scan counters; slot length is fixed whatever digit_en says.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_cnt <= '0;
            idx      <= '0;
        end else begin
            slot_cnt <= slot_last ? '0 : slot_cnt + 1'b1;
            if (slot_last) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
        end
    end

    // Double buffer. A load on the commit edge goes straight to the active
    // buffer so it is neither lost nor delayed by a whole frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_digits <= '0;
            shadow_dp     <= '0;
            shadow_en     <= '0;
            pending       <= 1'b0;
            active_digits <= '0;
            active_dp     <= '0;
            active_en     <= '0;
        end else begin
            if (load) begin
                shadow_digits <= digits_in;
                shadow_dp     <= dp_in;
                shadow_en     <= digit_en;
            end
            if (frame_wrap) begin
                pending <= 1'b0;
                if (load) begin
                    active_digits <= digits_in;
                    active_dp     <= dp_in;
                    active_en     <= digit_en;
                end else if (pending) begin
                    active_digits <= shadow_digits;
                    active_dp     <= shadow_dp;
                    active_en     <= shadow_en;
                end
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    // Stage 1: registered pin drivers. seg/dp only move on slot cycle 0,
    // which is always blank, so no lit digit ever sees a segment change.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an_p1          <= '1;
            seg_p1         <= SEG_OFF;
            dp_p1          <= 1'b1;
            load_ack_p1    <= 1'b0;
            frame_start_p1 <= 1'b0;
        end else begin
            an_p1          <= an_nxt;
            if (slot_cnt == '0) begin
                seg_p1 <= hex_to_seg(nibble);
                dp_p1  <= ~active_dp[idx];
            end
            frame_start_p1 <= frame_wrap;
            load_ack_p1    <= frame_wrap && (load || pending);
        end
    end

    assign an          = an_p1;
    assign seg         = seg_p1;
    assign dp          = dp_p1;
    assign load_ack    = load_ack_p1;
    assign frame_start = frame_start_p1;

endmodule

// File: tb/tb_seg7_scan_mux.sv
module tb_seg7_scan_mux;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  digit_en = '0;
    logic [2:0]  brightness = 3'd7;
    logic        load = 1'b0;

    logic        load_ack, frame_start, dp;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        ack18, fs18, dp18;
    logic [3:0]  an18;
    logic [6:0]  seg18;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seg7_scan_mux #(
        .NUM_DIGITS(4), .SLOT_CYCLES(8), .BLANK_CYCLES(2), .BRIGHT_W(3)
    ) dut (
        .clk(clk), .reset(reset), .digits_in(digits_in), .dp_in(dp_in),
        .digit_en(digit_en), .brightness(brightness), .load(load),
        .load_ack(load_ack), .frame_start(frame_start), .an(an), .seg(seg), .dp(dp)
    );

    seg7_scan_mux #(
        .NUM_DIGITS(4), .SLOT_CYCLES(18), .BLANK_CYCLES(2), .BRIGHT_W(3)
    ) dut18 (
        .clk(clk), .reset(reset), .digits_in(digits_in), .dp_in(dp_in),
        .digit_en(digit_en), .brightness(brightness), .load(load),
        .load_ack(ack18), .frame_start(fs18), .an(an18), .seg(seg18), .dp(dp18)
    );

    function automatic logic [6:0] font(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] e);
        digits_in = d;
        dp_in     = p;
        digit_en  = e;
        load      = 1'b1;
        tick;
        load      = 1'b0;
    endtask

    task automatic wait_fs(output bit seen);
        seen = (frame_start === 1'b1);
        for (int i = 0; i < 100 && !seen; i++) begin
            tick;
            seen = (frame_start === 1'b1);
        end
    endtask

    task automatic wait_fs18(output bit seen);
        seen = (fs18 === 1'b1);
        for (int i = 0; i < 300 && !seen; i++) begin
            tick;
            seen = (fs18 === 1'b1);
        end
    endtask

    task automatic test_reset;
        int lit, acks;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (an !== 4'hF) begin n_fail++; $display("FAIL reset_an: got %h want f", an); end
        n_checks++; if (seg !== 7'h7F) begin n_fail++; $display("FAIL reset_seg: got %h want 7f", seg); end
        n_checks++; if (dp !== 1'b1) begin n_fail++; $display("FAIL reset_dp: got %b want 1", dp); end
        n_checks++; if (load_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", load_ack); end
        n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_fs: got %b want 0", frame_start); end
        n_checks++; if (an18 !== 4'hF) begin n_fail++; $display("FAIL reset_an18: got %h want f", an18); end
        reset = 1'b1;
        lit = 0; acks = 0;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (an !== 4'hF) lit++;
            if (load_ack !== 1'b0) acks++;
        end
        n_checks++; if (lit != 0) begin n_fail++; $display("FAIL dark_before_load: lit cycles %0d want 0", lit); end
        n_checks++; if (acks != 0) begin n_fail++; $display("FAIL no_ack_before_load: acks %0d want 0", acks); end
    endtask

    task automatic test_basic_scan;
        bit seen;
        int k, c;
        logic [3:0] ea;
        logic [15:0] d;
        d = 16'h3210;
        brightness = 3'd7;
        do_load(d, 4'h0, 4'hF);
        wait_fs(seen);
        n_checks++; if (!seen) begin n_fail++; $display("FAIL basic_fs_seen: no frame_start"); end
        n_checks++; if (load_ack !== 1'b1) begin n_fail++; $display("FAIL basic_ack: got %b want 1", load_ack); end
        for (int j = 0; j < 32; j++) begin
            tick;
            k = j / 8; c = j % 8;
            ea = 4'hF;
            if (c >= 2) ea[k] = 1'b0;
            n_checks++; if (an !== ea) begin n_fail++; $display("FAIL basic_an j=%0d: got %h want %h", j, an, ea); end
            n_checks++; if (seg !== font(d[4*k +: 4])) begin n_fail++; $display("FAIL basic_seg j=%0d: got %h want %h", j, seg, font(d[4*k +: 4])); end
            n_checks++; if (dp !== 1'b1) begin n_fail++; $display("FAIL basic_dp j=%0d: got %b want 1", j, dp); end
        end
        n_checks++; if (frame_start !== 1'b1) begin n_fail++; $display("FAIL basic_period: fs %b want 1", frame_start); end
        n_checks++; if (load_ack !== 1'b0) begin n_fail++; $display("FAIL basic_single_ack: ack %b want 0", load_ack); end
    endtask

    task automatic test_hex_dp;
        bit seen;
        int k;
        logic [15:0] d;
        logic edp;
        d = 16'hFEDC;
        do_load(d, 4'b0100, 4'hF);
        wait_fs(seen);
        while (seen && load_ack !== 1'b1) wait_fs_next(seen);
        n_checks++; if (!seen) begin n_fail++; $display("FAIL hex_commit: no ack at frame_start"); end
        for (int j = 0; j < 32; j++) begin
            tick;
            k = j / 8;
            edp = (k == 2) ? 1'b0 : 1'b1;
            n_checks++; if (seg !== font(d[4*k +: 4])) begin n_fail++; $display("FAIL hex_seg j=%0d: got %h want %h", j, seg, font(d[4*k +: 4])); end
            n_checks++; if (dp !== edp) begin n_fail++; $display("FAIL hex_dp j=%0d: got %b want %b", j, dp, edp); end
        end
    endtask

    // Advance past the current frame_start and wait for the next one.
    task automatic wait_fs_next(output bit seen);
        tick;
        wait_fs(seen);
    endtask

    task automatic test_digit_en;
        bit seen;
        int k, c;
        logic [3:0] ea, en;
        en = 4'b1010;
        do_load(16'h3210, 4'h0, en);
        wait_fs(seen);
        n_checks++; if (!seen || load_ack !== 1'b1) begin n_fail++; $display("FAIL en_commit: seen %b ack %b want 1 1", seen, load_ack); end
        for (int j = 0; j < 32; j++) begin
            tick;
            k = j / 8; c = j % 8;
            ea = 4'hF;
            if (c >= 2 && en[k]) ea[k] = 1'b0;
            n_checks++; if (an !== ea) begin n_fail++; $display("FAIL en_an j=%0d: got %h want %h", j, an, ea); end
            n_checks++; if (frame_start !== (j == 31)) begin n_fail++; $display("FAIL en_period j=%0d: fs %b want %b", j, frame_start, (j == 31)); end
        end
    endtask

    task automatic test_back_to_back;
        bit seen;
        int acks;
        wait_fs(seen);
        repeat (3) tick;
        do_load(16'h1111, 4'h0, 4'hF);
        repeat (5) tick;
        do_load(16'h2222, 4'h0, 4'hF);
        acks = 0; seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick;
            if (load_ack === 1'b1) acks++;
            seen = (frame_start === 1'b1);
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL b2b_fs_seen: no frame_start"); end
        n_checks++; if (acks != 1) begin n_fail++; $display("FAIL b2b_single_ack: acks %0d want 1", acks); end
        for (int j = 0; j < 32; j++) begin
            if (j == 31) begin
                digits_in = 16'h3333;
                load = 1'b1;
            end
            tick;
            load = 1'b0;
            n_checks++; if (seg !== 7'h24) begin n_fail++; $display("FAIL b2b_seg2 j=%0d: got %h want 24", j, seg); end
            n_checks++; if (load_ack !== (j == 31)) begin n_fail++; $display("FAIL b2b_ack j=%0d: got %b want %b", j, load_ack, (j == 31)); end
        end
        n_checks++; if (frame_start !== 1'b1) begin n_fail++; $display("FAIL b2b_commit_fs: got %b want 1", frame_start); end
        for (int j = 0; j < 32; j++) begin
            tick;
            n_checks++; if (seg !== 7'h30) begin n_fail++; $display("FAIL b2b_seg3 j=%0d: got %h want 30", j, seg); end
            n_checks++; if (load_ack !== 1'b0) begin n_fail++; $display("FAIL b2b_noack j=%0d: got %b want 0", j, load_ack); end
        end
        n_checks++; if (frame_start !== 1'b1) begin n_fail++; $display("FAIL b2b_fs2: got %b want 1", frame_start); end
    endtask

    task automatic test_brightness;
        bit seen;
        int k, c, lit;
        logic [3:0] ea;
        brightness = 3'd1;
        do_load(16'h8888, 4'h0, 4'hF);
        wait_fs18(seen);
        while (seen && ack18 !== 1'b1) begin
            tick;
            wait_fs18(seen);
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL pwm_commit: no ack at frame_start"); end
        for (int pass = 0; pass < 2; pass++) begin
            lit = 0;
            for (int j = 0; j < 72; j++) begin
                tick;
                k = j / 18; c = j % 18;
                ea = 4'hF;
                if (c >= 2 && ((c - 2) % 8) <= int'(brightness)) ea[k] = 1'b0;
                if (an18 !== 4'hF) lit++;
                n_checks++; if (an18 !== ea) begin n_fail++; $display("FAIL pwm_an b=%0d j=%0d: got %h want %h", brightness, j, an18, ea); end
            end
            n_checks++; if (lit != ((pass == 0) ? 16 : 8)) begin n_fail++; $display("FAIL pwm_duty b=%0d: lit %0d want %0d", brightness, lit, (pass == 0) ? 16 : 8); end
            n_checks++; if (fs18 !== 1'b1) begin n_fail++; $display("FAIL pwm_period: fs %b want 1", fs18); end
            brightness = 3'd0;
        end
    endtask

    task automatic test_mid_reset;
        bit seen;
        int lit;
        brightness = 3'd7;
        do_load(16'h3210, 4'h0, 4'hF);
        wait_fs(seen);
        while (seen && load_ack !== 1'b1) wait_fs_next(seen);
        repeat (11) tick;
        n_checks++; if (an !== 4'b1101) begin n_fail++; $display("FAIL mid_pre_an: got %h want d", an); end
        reset = 1'b0;
        #2;
        n_checks++; if (an !== 4'hF) begin n_fail++; $display("FAIL mid_an: got %h want f", an); end
        n_checks++; if (seg !== 7'h7F) begin n_fail++; $display("FAIL mid_seg: got %h want 7f", seg); end
        n_checks++; if (dp !== 1'b1) begin n_fail++; $display("FAIL mid_dp: got %b want 1", dp); end
        repeat (2) tick;
        reset = 1'b1;
        lit = 0;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (an !== 4'hF) lit++;
        end
        n_checks++; if (lit != 0) begin n_fail++; $display("FAIL mid_dark_after: lit cycles %0d want 0", lit); end
    endtask

    initial begin
        test_reset;
        test_basic_scan;
        test_hex_dp;
        test_digit_en;
        test_back_to_back;
        test_brightness;
        test_mid_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
